md_unit: RTL and testbench

- Multiply/divide unit in the E stage of the pipelined CPU; consumes the two register operands read from the register file (after forwarding).
- Runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and holds the HI/LO architectural registers.
- Services MTHI/MTLO writes. HI/LO are read combinationally for MFHI/MFLO.
- Exposes busy to the hazard unit, which stalls any MD-class instruction while busy or start is high.

---
 rtl/md_unit_pkg.sv | 14 +
 rtl/md_unit.sv | 81 ++++++++
 tb/tb_md_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_defs: shared multiply/divide op encodings and default latencies.
package md_defs;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_unit.sv
// md_unit: fixed-latency multiply/divide unit holding the HI/LO registers.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  logic [CW-1:0]      r_cnt;
  logic               r_busy, r_commit;
  logic [31:0]        r_sh_hi, r_sh_lo, r_hi, r_lo;
  logic [63:0]        w_smul, w_umul, w_res;
  logic [31:0]        w_div_b, w_uq, w_ur;
  logic signed [32:0] w_sa, w_sb, w_sq, w_sr;
  logic               w_is_md, w_is_div;
  assign w_smul  = $signed(A) * $signed(B);
  assign w_umul  = {32'd0, A} * {32'd0, B};
  // Divisor of zero is replaced by one; that result is never committed.
  assign w_div_b = (B == 32'd0) ? 32'd1 : B;
  // 33-bit signed divide makes 0x80000000 / -1 wrap to 0x80000000 cleanly.
  assign w_sa    = {A[31], A};
  assign w_sb    = {w_div_b[31], w_div_b};
  assign w_sq    = w_sa / w_sb;
  assign w_sr    = w_sa % w_sb;
  assign w_uq    = A / w_div_b;
  assign w_ur    = A % w_div_b;
  assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign w_is_md  = w_is_div || (md_op == MD_MULT) || (md_op == MD_MULTU);
  always_comb begin
    w_res = (md_op == MD_MULT)  ? w_smul :
            (md_op == MD_MULTU) ? w_umul :
            (md_op == MD_DIV)   ? {w_sr[31:0], w_sq[31:0]} :
                                  {w_ur, w_uq};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
      r_sh_hi  <= '0;
      r_sh_lo  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        if (r_commit) begin
          r_hi <= r_sh_hi;
          r_lo <= r_sh_lo;
        end
      end
    end else if (start) begin
      if (w_is_md) begin
        r_sh_hi  <= w_res[63:32];
        r_sh_lo  <= w_res[31:0];
        r_cnt    <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        r_busy   <= 1'b1;
        r_commit <= !(w_is_div && B == 32'd0);
      end else if (md_op == MD_MTHI) begin
        r_hi <= A;
      end else if (md_op == MD_MTLO) begin
        r_lo <= A;
      end
    end
  end
  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit latency, arithmetic, MTHI/MTLO and reset.
module tb_md_unit;
  import md_defs::*;
  logic        clk = 1'b0;
  logic        reset, start, busy;
  md_op_e      md_op;
  logic [31:0] A, B, HI, LO;
  int          n_pass = 0;
  int          n_total = 0;
  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    step();
    start = 1'b0;
    md_op = MD_NONE;
  endtask
  task automatic wait_done(input string tag, input int exp_cycles);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk(tag, 32'(n), 32'(exp_cycles));
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = MD_NONE;
    A = '0;
    B = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    run_op(MD_MULT, 32'hFFFFFFFD, 32'h00000007);
    wait_done("mult_cycles", 5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFEB);
    run_op(MD_MULTU, 32'hFFFFFFFD, 32'h00000007);
    wait_done("multu_cycles", 5);
    chk("multu_hi", HI, 32'h00000006);
    chk("multu_lo", LO, 32'hFFFFFFEB);
    run_op(MD_DIV, 32'h00000007, 32'hFFFFFFFE);
    wait_done("div_cycles", 10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'h00000001);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done("divneg_cycles", 10);
    chk("divneg_lo", LO, 32'hFFFFFFFD);
    chk("divneg_hi", HI, 32'hFFFFFFFF);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("divovf_cycles", 10);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'h00000000);
    run_op(MD_DIVU, 32'd100, 32'd7);
    wait_done("divu_cycles", 10);
    chk("divu_lo", LO, 32'h0000000E);
    chk("divu_hi", HI, 32'h00000002);
    run_op(MD_MTHI, 32'h12345678, 32'h0);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo", LO, 32'h0000000E);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    run_op(MD_MTLO, 32'h9ABCDEF0, 32'h0);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_hi", HI, 32'h12345678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    run_op(MD_DIVU, 32'd55, 32'd0);
    wait_done("div0_cycles", 10);
    chk("div0_hi", HI, 32'h12345678);
    chk("div0_lo", LO, 32'h9ABCDEF0);
    run_op(MD_MULT, 32'h00010000, 32'h00010000);
    step();
    start = 1'b1;
    md_op = MD_MTLO;
    A = 32'hDEADBEEF;
    B = 32'h00000005;
    step();
    start = 1'b0;
    md_op = MD_NONE;
    chk("ign_lo_mid", LO, 32'h9ABCDEF0);
    chk("ign_busy_mid", {31'd0, busy}, 32'd1);
    wait_done("ign_cycles", 3);
    chk("ign_hi", HI, 32'h00000001);
    chk("ign_lo", LO, 32'h00000000);
    step();
    chk("ign_idle", {31'd0, busy}, 32'd0);
    run_op(MD_DIV, 32'd100, 32'd3);
    step();
    step();
    step();
    chk("rst_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("rst_nocommit_hi", HI, 32'd0);
    chk("rst_nocommit_lo", LO, 32'd0);
    run_op(MD_MULT, 32'd3, 32'd4);
    wait_done("mult34_cycles", 5);
    chk("mult34_lo", LO, 32'h0000000C);
    chk("mult34_hi", HI, 32'h00000000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
